dram_word_assembler: RTL and testbench

- Sits directly downstream of the DRAM read-address sequencer.
- Gathers consecutive DATA_IN_DRAM_WIDTH-bit DRAM read beats into one full-width word for the selected on-chip target: parameter register, weight memory, signal ROM-image or input-feature BRAM.
- Drives that target's write strobe and write address.
- Raises a completion flag once the requested number of words has been written.

---
 rtl/dram_word_assembler_pkg.sv | 50 +++++
 rtl/dram_word_assembler_packer.sv | 48 ++++
 rtl/dram_word_assembler.sv | 183 ++++++++++++++++++
 tb/tb_dram_word_assembler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_word_assembler_pkg.sv
// Shared encodings and sizing helpers for the DRAM word assembler.
// Holds the target-select and FSM state encodings plus constant functions
// that derive each target's word width and beats-per-word.
package dram_word_assembler_pkg;

  // Target-select encoding, also the bit index into the one-hot write strobe.
  typedef enum logic [1:0] {
    TGT_PARAM  = 2'd0,
    TGT_WEIGHT = 2'd1,
    TGT_SIGNAL = 2'd2,
    TGT_INPUT  = 2'd3
  } target_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num,
                                           input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Full-word width of each on-chip target.
  function automatic int unsigned target_width(input target_e     tgt,
                                               input int unsigned input_w,
                                               input int unsigned weight_w,
                                               input int unsigned signal_w,
                                               input int unsigned param_w);
    int unsigned w;
    w = param_w;
    case (tgt)
      TGT_PARAM:  w = param_w;
      TGT_WEIGHT: w = weight_w;
      TGT_SIGNAL: w = signal_w;
      TGT_INPUT:  w = input_w;
      default:    w = param_w;
    endcase
    return w;
  endfunction

  // Number of DRAM beats needed to fill one word of the given width.
  function automatic int unsigned beats_for(input int unsigned width,
                                            input int unsigned beat_w);
    return ceil_div(width, beat_w);
  endfunction

endpackage

// File: rtl/dram_word_assembler_packer.sv
// word_shift_packer: drops each accepted DRAM beat into its slot of the
// assembled word, masks off bits beyond the target width and clears the
// word between transfers or after it has been written.
module word_shift_packer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PACK_WIDTH = 128,
  parameter int unsigned MAX_BEATS  = 4,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [CNT_WIDTH-1:0]  slot,
  input  logic [DATA_WIDTH-1:0] beat_data,
  input  logic [PACK_WIDTH-1:0] mask,
  output logic [PACK_WIDTH-1:0] pack
);

  localparam int unsigned EXT_WIDTH = MAX_BEATS * DATA_WIDTH;

  logic [PACK_WIDTH-1:0] pack_q;
  logic [EXT_WIDTH-1:0]  inserted;

  // Current word with the incoming beat written into its slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    inserted                   = '0;
    inserted[PACK_WIDTH-1:0]   = pack_q;
    inserted[slot*DATA_WIDTH +: DATA_WIDTH] = beat_data;
  end

  // Word register: clear wins over load so a flushed beat is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this is a single small register, not a memory array, so it is reset to give a clean all-zero output.
    if (!rst_n) begin
      pack_q <= '0;
    end else if (clear) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      pack_q <= '0;
    end else if (load) begin
      pack_q <= inserted[PACK_WIDTH-1:0] & mask;
    end
  end

  assign pack = pack_q;

endmodule

// File: rtl/dram_word_assembler.sv
// dram_word_assembler: gathers DRAM read beats into full-width words for the
// selected on-chip target, strobes that target's write enable and address,
// and pulses bram_ready_o when the requested word count has been written.
// Build option DRAM_ASSEMBLER_MSB_FIRST_EN: first beat lands in the most
// significant slot of the target-width field instead of the LSBs.
module dram_word_assembler
  import dram_word_assembler_pkg::*;
#(
  parameter int unsigned DATA_IN_DRAM_WIDTH = 32,
  parameter int unsigned N_ROWS_ARRAY       = 16,
  parameter int unsigned I_WIDTH            = 8,
  parameter int unsigned F_WIDTH            = 8,
  parameter int unsigned ROM_SIG_WIDTH      = 100,
  parameter int unsigned PARAMETERS_WIDTH   = 50,
  parameter int unsigned WR_ADDR_WIDTH      = 16,
  parameter int unsigned PACK_WIDTH         = 128
) (
  input  logic                          clk_i,
  input  logic                          general_rst_n_i,
  input  logic                          start_i,
  input  logic [1:0]                    target_sel_i,
  input  logic [WR_ADDR_WIDTH-1:0]      n_words_i,
  input  logic                          flush_i,
  input  logic [DATA_IN_DRAM_WIDTH-1:0] dram_data_i,
  input  logic                          dram_valid_i,
  output logic                          dram_ready_o,
  output logic [PACK_WIDTH-1:0]         pack_data_o,
  output logic [3:0]                    wr_en_o,
  output logic [WR_ADDR_WIDTH-1:0]      wr_addr_o,
  output logic                          busy_o,
  output logic                          bram_ready_o
);

  localparam int unsigned W_INPUT  = I_WIDTH * N_ROWS_ARRAY;
  localparam int unsigned W_WEIGHT = F_WIDTH * N_ROWS_ARRAY;

  localparam int unsigned W_PARAM_T  = target_width(TGT_PARAM,  W_INPUT, W_WEIGHT, ROM_SIG_WIDTH, PARAMETERS_WIDTH);
  localparam int unsigned W_WEIGHT_T = target_width(TGT_WEIGHT, W_INPUT, W_WEIGHT, ROM_SIG_WIDTH, PARAMETERS_WIDTH);
  localparam int unsigned W_SIGNAL_T = target_width(TGT_SIGNAL, W_INPUT, W_WEIGHT, ROM_SIG_WIDTH, PARAMETERS_WIDTH);
  localparam int unsigned W_INPUT_T  = target_width(TGT_INPUT,  W_INPUT, W_WEIGHT, ROM_SIG_WIDTH, PARAMETERS_WIDTH);

  localparam int unsigned MAX_BEATS = ceil_div(PACK_WIDTH, DATA_IN_DRAM_WIDTH);
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);

  localparam logic [CNT_W-1:0] BEATS_PARAM  = CNT_W'(beats_for(W_PARAM_T,  DATA_IN_DRAM_WIDTH));
  localparam logic [CNT_W-1:0] BEATS_WEIGHT = CNT_W'(beats_for(W_WEIGHT_T, DATA_IN_DRAM_WIDTH));
  localparam logic [CNT_W-1:0] BEATS_SIGNAL = CNT_W'(beats_for(W_SIGNAL_T, DATA_IN_DRAM_WIDTH));
  localparam logic [CNT_W-1:0] BEATS_INPUT  = CNT_W'(beats_for(W_INPUT_T,  DATA_IN_DRAM_WIDTH));

  localparam logic [PACK_WIDTH-1:0] MASK_PARAM  = {PACK_WIDTH{1'b1}} >> (PACK_WIDTH - W_PARAM_T);
  localparam logic [PACK_WIDTH-1:0] MASK_WEIGHT = {PACK_WIDTH{1'b1}} >> (PACK_WIDTH - W_WEIGHT_T);
  localparam logic [PACK_WIDTH-1:0] MASK_SIGNAL = {PACK_WIDTH{1'b1}} >> (PACK_WIDTH - W_SIGNAL_T);
  localparam logic [PACK_WIDTH-1:0] MASK_INPUT  = {PACK_WIDTH{1'b1}} >> (PACK_WIDTH - W_INPUT_T);

  localparam logic [WR_ADDR_WIDTH-1:0] ADDR_MAX = {WR_ADDR_WIDTH{1'b1}};

  state_e                   state_q, state_d;
  target_e                  target_q;
  logic [WR_ADDR_WIDTH-1:0] n_words_q;
  logic [WR_ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]         beat_q;
  logic [CNT_W-1:0]         beats_cur;
  logic [PACK_WIDTH-1:0]    mask_cur;
  logic [CNT_W-1:0]         slot;
  logic                     accept;
  logic                     last_beat;
  logic                     word_last;
  logic                     pack_clear;

  // Beats-per-word and width mask of the latched target.
  always_comb begin
    beats_cur = BEATS_PARAM;
    mask_cur  = MASK_PARAM;
    case (target_q)
      TGT_PARAM:  begin beats_cur = BEATS_PARAM;  mask_cur = MASK_PARAM;  end
      TGT_WEIGHT: begin beats_cur = BEATS_WEIGHT; mask_cur = MASK_WEIGHT; end
      TGT_SIGNAL: begin beats_cur = BEATS_SIGNAL; mask_cur = MASK_SIGNAL; end
      TGT_INPUT:  begin beats_cur = BEATS_INPUT;  mask_cur = MASK_INPUT;  end
      default:    begin beats_cur = BEATS_PARAM;  mask_cur = MASK_PARAM;  end
    endcase
  end

  assign accept     = (state_q == ST_COLLECT) && dram_valid_i;
  assign last_beat  = (beat_q == beats_cur - CNT_W'(1));
  // The address counter restarts at zero each transfer, so it doubles as the word index.
  assign word_last  = (addr_q == n_words_q - WR_ADDR_WIDTH'(1)) || (addr_q == ADDR_MAX);
  assign pack_clear = flush_i || (state_q == ST_WRITE) || ((state_q == ST_IDLE) && start_i);

`ifdef DRAM_ASSEMBLER_MSB_FIRST_EN
  assign slot = beats_cur - CNT_W'(1) - beat_q;
`else
  assign slot = beat_q;
`endif

  word_shift_packer #(
    .DATA_WIDTH (DATA_IN_DRAM_WIDTH),
    .PACK_WIDTH (PACK_WIDTH),
    .MAX_BEATS  (MAX_BEATS),
    .CNT_WIDTH  (CNT_W)
  ) u_packer (
    .clk       (clk_i),
    .rst_n     (general_rst_n_i),
    .clear     (pack_clear),
    .load      (accept),
    .slot      (slot),
    .beat_data (dram_data_i),
    .mask      (mask_cur),
    .pack      (pack_data_o)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge general_rst_n_i) begin
    if (!general_rst_n_i) state_q <= ST_IDLE;
    else                  state_q <= state_d;
  end

  // Next state and control outputs; flush overrides any strobe and forces IDLE.
  always_comb begin
    state_d      = state_q;
    dram_ready_o = 1'b0;
    wr_en_o      = 4'b0000;
    bram_ready_o = 1'b0;
    busy_o       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = (n_words_i == '0) ? ST_DONE : ST_COLLECT;
      end
      ST_COLLECT: begin
        dram_ready_o = 1'b1;
        if (accept && last_beat) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en_o = 4'b0001 << target_q;
        state_d = word_last ? ST_DONE : ST_COLLECT;
      end
      ST_DONE: begin
        bram_ready_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d      = ST_IDLE;
      wr_en_o      = 4'b0000;
      bram_ready_o = 1'b0;
    end
  end

  // Transfer context: latched target/count, beat counter and saturating address.
  always_ff @(posedge clk_i or negedge general_rst_n_i) begin
    if (!general_rst_n_i) begin
      target_q  <= TGT_PARAM;
      n_words_q <= '0;
      addr_q    <= '0;
      beat_q    <= '0;
    end else if (flush_i) begin
      beat_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            target_q  <= target_e'(target_sel_i);
            n_words_q <= n_words_i;
            addr_q    <= '0;
            beat_q    <= '0;
          end
        end
        ST_COLLECT: begin
          if (accept) beat_q <= beat_q + CNT_W'(1);
        end
        ST_WRITE: begin
          beat_q <= '0;
          if (addr_q != ADDR_MAX) addr_q <= addr_q + WR_ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign wr_addr_o = addr_q;

endmodule

// File: tb/tb_dram_word_assembler.sv
// Self-checking bench for dram_word_assembler: a transaction-level model
// predicts every write strobe, address, data word and completion pulse from
// the accepted beat stream; directed cases pin literal values.
module tb_dram_word_assembler;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   target_sel;
  logic [15:0]  n_words;
  logic         flush;
  logic [31:0]  dram_data;
  logic         dram_valid;
  logic         dram_ready;
  logic [127:0] pack_data;
  logic [3:0]   wr_en;
  logic [15:0]  wr_addr;
  logic         busy;
  logic         bram_ready;

  dram_word_assembler dut (
    .clk_i           (clk),
    .general_rst_n_i (rst_n),
    .start_i         (start),
    .target_sel_i    (target_sel),
    .n_words_i       (n_words),
    .flush_i         (flush),
    .dram_data_i     (dram_data),
    .dram_valid_i    (dram_valid),
    .dram_ready_o    (dram_ready),
    .pack_data_o     (pack_data),
    .wr_en_o         (wr_en),
    .wr_addr_o       (wr_addr),
    .busy_o          (busy),
    .bram_ready_o    (bram_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- upstream beat source ----------------
  logic [31:0] bq[$];
  int          mode = 0;     // 0 always valid, 1 toggle, 2 random
  logic        hs_last = 1'b0;
  logic        tog = 1'b0;

  initial begin
    dram_valid = 1'b0;
    dram_data  = '0;
    forever begin
      logic gate;
      @(posedge clk); #1;
      if (hs_last && bq.size() > 0) void'(bq.pop_front());
      tog  = ~tog;
      gate = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      dram_valid = (bq.size() > 0) && gate;
      dram_data  = (bq.size() > 0) ? bq[0] : $urandom;
    end
  end

  // ---------------- behavioural model ----------------
  function automatic int tgt_width(input int t);
    case (t)
      0: return 50;
      1: return 128;
      2: return 100;
      default: return 128;
    endcase
  endfunction

  function automatic int beats_of(input int t);
    return (tgt_width(t) + 31) / 32;
  endfunction

  logic [31:0] mb[4];

  function automatic logic [127:0] assemble(input int t);
    int w, b;
    logic [127:0] acc, beat;
    w = tgt_width(t);
    b = beats_of(t);
    acc = '0;
    for (int k = 0; k < b; k++) begin
      beat = 128'(mb[k]);
`ifdef DRAM_ASSEMBLER_MSB_FIRST_EN
      acc |= beat << (32 * (b - 1 - k));
`else
      acc |= beat << (32 * k);
`endif
    end
    return acc & (~128'd0 >> (128 - w));
  endfunction

  typedef struct {
    logic [3:0]   en;
    int           addr;
    logic [127:0] data;
    int           cyc;
  } wr_rec_t;

  wr_rec_t      wlog[$];
  int           cyc = 0;
  int           n_done = 0;
  int           done_cyc = -1;
  int           start_cyc = -1;

  logic         m_active = 1'b0;
  logic         m_pend_wr = 1'b0;
  logic         m_pend_done = 1'b0;
  int           m_tgt = 0;
  int           m_n = 0;
  int           m_addr = 0;
  int           m_cnt = 0;
  logic [127:0] m_exp = '0;

  // Compare process: checks the DUT against the model every cycle, then advances the model.
  always @(negedge clk) begin
    logic [3:0] exp_en;
    cyc++;
    if (!rst_n) begin
      m_active = 1'b0; m_pend_wr = 1'b0; m_pend_done = 1'b0;
      m_cnt = 0; m_addr = 0; hs_last = 1'b0;
      check("reset_ctl", 128'({busy, dram_ready, bram_ready, wr_en, wr_addr}), '0);
      check("reset_pack", pack_data, '0);
    end else begin
      hs_last = dram_valid && dram_ready;
      exp_en  = (m_pend_wr && !flush) ? (4'b0001 << m_tgt) : 4'b0000;
      check("wr_en", 128'(wr_en), 128'(exp_en));
      if (exp_en != 4'b0000) begin
        check("wr_addr", 128'(wr_addr), 128'(m_addr));
        check("pack_data", pack_data, m_exp);
      end
      check("bram_ready", 128'(bram_ready), 128'(m_pend_done && !flush));
      check("dram_ready", 128'(dram_ready), 128'(m_active && !m_pend_wr && !m_pend_done));
      check("busy", 128'(busy), 128'(m_active));
      if (wr_en != 4'b0000) wlog.push_back('{wr_en, int'(wr_addr), pack_data, cyc});
      if (bram_ready) begin n_done++; done_cyc = cyc; end
      if (start && !m_active) start_cyc = cyc;

      if (flush) begin
        m_active = 1'b0; m_pend_wr = 1'b0; m_pend_done = 1'b0; m_cnt = 0;
      end else if (m_pend_done) begin
        m_active = 1'b0; m_pend_done = 1'b0;
      end else if (m_pend_wr) begin
        m_pend_wr = 1'b0;
        if (m_addr + 1 == m_n || m_addr == 65535) m_pend_done = 1'b1;
        if (m_addr != 65535) m_addr++;
      end else if (m_active) begin
        if (dram_valid) begin
          mb[m_cnt] = dram_data;
          m_cnt++;
          if (m_cnt == beats_of(m_tgt)) begin
            m_exp = assemble(m_tgt);
            m_pend_wr = 1'b1;
            m_cnt = 0;
          end
        end
      end else if (start) begin
        m_active = 1'b1;
        m_tgt = int'(target_sel);
        m_n = int'(n_words);
        m_addr = 0;
        m_cnt = 0;
        m_pend_done = (n_words == 16'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_xfer(input logic [1:0] t, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; target_sel = t; n_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (busy && i < budget);
    check("idle_timeout", 128'(busy), '0);
  endtask

  task automatic new_case();
    wlog.delete();
    n_done = 0;
    done_cyc = -1;
    start_cyc = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w0, w1;
    rst_n = 1'b1; start = 1'b0; target_sel = '0; n_words = '0; flush = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Weights, two words, back-to-back beats.
    new_case();
    mode = 0;
    for (int k = 1; k <= 8; k++) bq.push_back(32'h11111111 * k);
    start_xfer(2'd1, 16'd2);
    wait_idle(100);
`ifdef DRAM_ASSEMBLER_MSB_FIRST_EN
    w0 = 128'h11111111_22222222_33333333_44444444;
    w1 = 128'h55555555_66666666_77777777_88888888;
`else
    w0 = 128'h44444444_33333333_22222222_11111111;
    w1 = 128'h88888888_77777777_66666666_55555555;
`endif
    check("w_count", 128'(wlog.size()), 128'd2);
    if (wlog.size() >= 2) begin
      check("w0_en",   128'(wlog[0].en),   128'(4'b0010));
      check("w0_addr", 128'(wlog[0].addr), 128'd0);
      check("w0_data", wlog[0].data, w0);
      check("w1_addr", 128'(wlog[1].addr), 128'd1);
      check("w1_data", wlog[1].data, w1);
      check("w_done_lat", 128'(done_cyc - wlog[1].cyc), 128'd1);
    end
    check("w_done_cnt", 128'(n_done), 128'd1);

    // Parameters, single word, all-ones beats masked to 50 bits.
    new_case();
    bq.push_back(32'hFFFFFFFF);
    bq.push_back(32'hFFFFFFFF);
    start_xfer(2'd0, 16'd1);
    wait_idle(100);
    check("p_count", 128'(wlog.size()), 128'd1);
    if (wlog.size() >= 1) begin
      check("p_en",   128'(wlog[0].en), 128'(4'b0001));
      check("p_data", wlog[0].data, 128'h0003FFFF_FFFFFFFF);
    end

    // Inputs, three words, valid toggling; a start while busy must be ignored.
    new_case();
    mode = 1;
    for (int k = 0; k < 12; k++) bq.push_back($urandom);
    start_xfer(2'd3, 16'd3);
    repeat (3) @(posedge clk);
    start_xfer(2'd0, 16'd5);
    wait_idle(200);
    check("i_count", 128'(wlog.size()), 128'd3);
    for (int i = 0; i < wlog.size(); i++) begin
      check("i_en",   128'(wlog[i].en),   128'(4'b1000));
      check("i_addr", 128'(wlog[i].addr), 128'(i));
    end
    check("i_beats_left", 128'(bq.size()), 128'd0);
    check("i_done_cnt", 128'(n_done), 128'd1);

    // Signals, flush after three beats of word 1, then restart.
    new_case();
    mode = 0;
    for (int k = 0; k < 7; k++) bq.push_back($urandom);
    start_xfer(2'd2, 16'd3);
    begin
      int i;
      i = 0;
      while (bq.size() > 0 && i < 100) begin @(negedge clk); i++; end
    end
    check("f_beats_fed", 128'(bq.size()), 128'd0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("f_count", 128'(wlog.size()), 128'd1);
    if (wlog.size() >= 1) check("f_addr", 128'(wlog[0].addr), 128'd0);
    check("f_no_done", 128'(n_done), 128'd0);
    check("f_idle", 128'(busy), 128'd0);
    for (int k = 0; k < 4; k++) bq.push_back($urandom);
    start_xfer(2'd2, 16'd1);
    wait_idle(100);
    check("f_restart_count", 128'(wlog.size()), 128'd2);
    if (wlog.size() >= 2) check("f_restart_addr", 128'(wlog[1].addr), 128'd0);

    // Zero-word request completes at once.
    new_case();
    start_xfer(2'd1, 16'd0);
    wait_idle(20);
    check("z_no_write", 128'(wlog.size()), 128'd0);
    check("z_done_lat", 128'(done_cyc - start_cyc), 128'd1);

    // Random transfers checked by the model.
    for (int r = 0; r < 8; r++) begin
      int t, n;
      new_case();
      t    = $urandom_range(0, 3);
      n    = $urandom_range(1, 4);
      mode = $urandom_range(0, 2);
      for (int k = 0; k < n * beats_of(t); k++) bq.push_back($urandom);
      start_xfer(2'(t), 16'(n));
      wait_idle(400);
      check("r_count", 128'(wlog.size()), 128'(n));
      check("r_beats_left", 128'(bq.size()), 128'd0);
    end

    // Asynchronous reset mid-transfer.
    new_case();
    mode = 0;
    for (int k = 0; k < 8; k++) bq.push_back($urandom);
    start_xfer(2'd1, 16'd2);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("ar_ctl", 128'({busy, dram_ready, bram_ready, wr_en, wr_addr}), '0);
    check("ar_pack", pack_data, '0);
    bq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("ar_no_write", 128'(wlog.size()), 128'd0);
    bq.push_back($urandom);
    bq.push_back($urandom);
    start_xfer(2'd0, 16'd1);
    wait_idle(100);
    check("ar_recover", 128'(wlog.size()), 128'd1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
